// File: rtl/mc_result_uart_tx.sv
// mc_result_uart_tx: snapshots the pi_yes/pi_no hit counters on a rising edge of
// finish and sends them as one 8N1 UART frame, LSB first, with this byte order:
//   SYNC_BYTE, pi_yes[31:24..7:0], pi_no[31:24..7:0]
// Optional feature macro: MC_TX_CHECKSUM_EN appends a 10th byte holding the XOR
// of bytes 1..8. The sync byte is not included in that XOR.
// All outputs are registered. Reset is synchronous and active-low.
module mc_result_uart_tx #(
    parameter int          CLK_DIV   = 868,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        finish,
    input  logic [31:0] pi_yes,
    input  logic [31:0] pi_no,
    output logic        txd,
    output logic        busy,
    output logic        frame_done,
    output logic        overrun
);

    localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [TW-1:0] TIMER_LOAD = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] TIMER_ZERO = TW'(0);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
`ifdef MC_TX_CHECKSUM_EN
    localparam logic [3:0] LAST_BYTE = 4'd9;
`else
    localparam logic [3:0] LAST_BYTE = 4'd8;
`endif

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t         r_state;
    logic           r_finish_q;
    logic [TW-1:0]  r_timer;
    logic [2:0]     r_bit_cnt;
    logic [3:0]     r_byte_idx;
    logic [7:0]     r_shift;
    logic [63:0]    r_shadow;
    logic           r_txd;
    logic           r_busy;
    logic           r_frame_done;
    logic           r_overrun;
    logic           w_start;

`ifdef MC_TX_CHECKSUM_EN
    // XOR of the eight payload bytes of a snapshot.
    function automatic logic [7:0] payload_xor(input logic [63:0] snap);
        return snap[63:56] ^ snap[55:48] ^ snap[47:40] ^ snap[39:32] ^
               snap[31:24] ^ snap[23:16] ^ snap[15:8]  ^ snap[7:0];
    endfunction
`endif

    // Byte number idx of the frame, taken from the latched snapshot.
    function automatic logic [7:0] frame_byte(input logic [3:0] idx, input logic [63:0] snap);
        case (idx)
            4'd0:    return SYNC_BYTE;
            4'd1:    return snap[63:56];
            4'd2:    return snap[55:48];
            4'd3:    return snap[47:40];
            4'd4:    return snap[39:32];
            4'd5:    return snap[31:24];
            4'd6:    return snap[23:16];
            4'd7:    return snap[15:8];
            4'd8:    return snap[7:0];
`ifdef MC_TX_CHECKSUM_EN
            4'd9:    return payload_xor(snap);
`endif
            default: return 8'hFF;
        endcase
    endfunction

    assign w_start    = finish & ~r_finish_q;
    assign txd        = r_txd;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign overrun    = r_overrun;

    // Frame FSM: edge detect, snapshot, bit timing, serialisation and status flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_finish_q   <= 1'b0;
            r_timer      <= TIMER_ZERO;
            r_bit_cnt    <= 3'd0;
            r_byte_idx   <= 4'd0;
            r_shift      <= 8'hFF;
            r_shadow     <= 64'd0;
            r_txd        <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_finish_q   <= finish;
            r_frame_done <= 1'b0;
            // Busy is judged on the registered state. This includes the cycle that leaves STOP.
            if (w_start && (r_state != IDLE)) begin
                r_overrun <= 1'b1;
            end else begin
                r_overrun <= r_overrun;
            end
            case (r_state)
                IDLE: begin
                    r_txd <= 1'b1;
                    if (w_start) begin
                        r_shadow   <= {pi_yes, pi_no};
                        r_byte_idx <= 4'd0;
                        r_shift    <= SYNC_BYTE;
                        r_timer    <= TIMER_LOAD;
                        r_txd      <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= START;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                START: begin
                    if (r_timer == TIMER_ZERO) begin
                        r_timer   <= TIMER_LOAD;
                        r_bit_cnt <= 3'd0;
                        r_txd     <= r_shift[0];
                        r_state   <= DATA;
                    end else begin
                        r_timer <= r_timer - TIMER_ONE;
                    end
                end
                DATA: begin
                    if (r_timer == TIMER_ZERO) begin
                        r_timer <= TIMER_LOAD;
                        if (r_bit_cnt == 3'd7) begin
                            r_txd   <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_txd     <= r_shift[1];
                        end
                    end else begin
                        r_timer <= r_timer - TIMER_ONE;
                    end
                end
                STOP: begin
                    if (r_timer == TIMER_ZERO) begin
                        if (r_byte_idx == LAST_BYTE) begin
                            r_busy       <= 1'b0;
                            r_frame_done <= 1'b1;
                            r_state      <= IDLE;
                        end else begin
                            // The next start bit follows the stop bit directly, with no idle gap.
                            r_byte_idx <= r_byte_idx + 4'd1;
                            r_shift    <= frame_byte(r_byte_idx + 4'd1, r_shadow);
                            r_timer    <= TIMER_LOAD;
                            r_txd      <= 1'b0;
                            r_state    <= START;
                        end
                    end else begin
                        r_timer <= r_timer - TIMER_ONE;
                    end
                end
                default: begin
                    r_txd   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
